rd_xfer_bndry_tracker: RTL and testbench

- Parametrised successor of the read page-boundary checker in the octal/xSPI read datapath; clocked by the inverted DQS strobe.
- Tracks every received beat's byte address, gates RCV_DQ_FIFO writes, and reports page-boundary splits and transfer completion to the data shifter.
- New over the previous generation: configurable beat width, selectable wrap window (16-128 B), hybrid wrap-then-increment, beat-length countdown with done flag, parametrised minimum-DQS count.
- rd_last_addr is always the next byte address to fetch, so a split transfer resumes directly from it.

---
 rtl/rd_xfer_bndry_tracker.sv | 167 ++++++++++++++++
 tb/tb_rd_xfer_bndry_tracker.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_xfer_bndry_tracker.sv
// Per-beat read address tracker for the xSPI receive path, clocked by the inverted DQS strobe.
// It gates RCV_DQ_FIFO writes and reports page-boundary splits, wrap progress and transfer completion.
module rd_xfer_bndry_tracker #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int BEAT_BYTES     = 2,
   parameter int LEN_WIDTH      = 12,
   parameter int MIN_DQS_EDGES  = 4
) (
   input  logic                      dqs_inv,
   input  logic                      rst_n,
   input  logic [3:0]                mem_page_size,
   input  logic                      mr_access_reg,
   input  logic                      start_track,
   input  logic                      stop_read,
   input  logic                      wr_rd,
   input  logic [1:0]                xfer_btype,
   input  logic [1:0]                wrap_size,
   input  logic                      hybrid_wrap,
   input  logic                      rbx_en,
   input  logic [AXI_ADDR_WIDTH-1:0] first_addr,
   input  logic [LEN_WIDTH-1:0]      xfer_mem_len,
   output logic                      rcv_dq_fifo_wr_en,
   output logic                      cnt,
   output logic                      min_dqs_cnt_rch,
   output logic                      rd_pg_bndry_expired,
   output logic                      xfer_done,
   output logic                      wrap_phase,
   output logic [AXI_ADDR_WIDTH-1:0] rd_last_addr,
   output logic [LEN_WIDTH-1:0]      beats_left
);

   localparam int BB_LOG = $clog2(BEAT_BYTES);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RUN     = 2'd1;
   localparam logic [1:0] ST_EXPIRED = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   localparam logic [1:0] BTYPE_WRAP = 2'b10;

   localparam logic [AXI_ADDR_WIDTH-1:0] BEAT_INC   = AXI_ADDR_WIDTH'(BEAT_BYTES);
   localparam logic [AXI_ADDR_WIDTH-1:0] ALIGN_MASK = ~AXI_ADDR_WIDTH'(BEAT_BYTES - 1);
   localparam logic [3:0]                DQS_LAST   = 4'(MIN_DQS_EDGES - 1);

   logic [1:0]                state;
   logic                      wr_en_int;
   logic [7:0]                wrap_cnt;
   logic [3:0]                dqs_cnt;

   logic                      idle_start;
   logic                      capture;
   logic [AXI_ADDR_WIDTH-1:0] cur_addr;
   logic                      cur_wrap;
   logic [7:0]                win_bytes;
   logic [7:0]                win_beats;
   logic [AXI_ADDR_WIDTH-1:0] win_mask;
   logic [AXI_ADDR_WIDTH-1:0] win_base;
   logic [AXI_ADDR_WIDTH-1:0] lin_addr;
   logic [AXI_ADDR_WIDTH-1:0] next_addr;
   logic [7:0]                wrap_cnt_next;
   logic                      win_complete;
   logic [LEN_WIDTH-1:0]      len_one;
   logic [LEN_WIDTH-1:0]      len_eff;
   logic [LEN_WIDTH-1:0]      beats_next;
   logic                      done_now;
   logic                      page_valid;
   logic [AXI_ADDR_WIDTH-1:0] page_mask;
   logic                      page_split;

   assign idle_start = (state == ST_IDLE) && start_track && !wr_rd;
   assign capture    = !stop_read && (idle_start || (state == ST_RUN));

   // The first beat comes from first_addr; every later beat from the stored resume address.
   assign cur_addr = (state == ST_IDLE) ? (first_addr & ALIGN_MASK) : rd_last_addr;
   assign cur_wrap = (state == ST_IDLE) ? (xfer_btype == BTYPE_WRAP) : wrap_phase;

   assign win_bytes     = 8'd16 << wrap_size;
   assign win_beats     = win_bytes >> BB_LOG;
   assign win_mask      = AXI_ADDR_WIDTH'(win_bytes - 8'd1);
   assign win_base      = cur_addr & ~win_mask;
   assign lin_addr      = cur_addr + BEAT_INC;
   assign wrap_cnt_next = ((state == ST_IDLE) ? 8'd0 : wrap_cnt) + 8'd1;
   assign win_complete  = cur_wrap && (wrap_cnt_next == win_beats);

   always_comb begin
      next_addr = lin_addr;
      if (cur_wrap) begin
         if (win_complete && hybrid_wrap)
            next_addr = win_base + AXI_ADDR_WIDTH'(win_bytes);
         else
            next_addr = win_base | (lin_addr & win_mask);
      end
   end

   // A pure wrap burst can never run past its window, so the length is clamped to it.
   always_comb begin
      len_one = (xfer_mem_len == '0) ? LEN_WIDTH'(1) : xfer_mem_len;
      len_eff = len_one;
      if ((xfer_btype == BTYPE_WRAP) && !hybrid_wrap && (len_one > LEN_WIDTH'(win_beats)))
         len_eff = LEN_WIDTH'(win_beats);
   end

   assign beats_next = ((state == ST_IDLE) ? len_eff : beats_left) - LEN_WIDTH'(1);
   assign done_now   = (beats_next == '0);
   assign page_valid = (mem_page_size >= 4'd6);
   assign page_mask  = AXI_ADDR_WIDTH'((64'd1 << mem_page_size) - 64'd1);
   assign page_split = !cur_wrap && !rbx_en && page_valid &&
                       ((next_addr & page_mask) == '0) && !done_now;

   assign rcv_dq_fifo_wr_en = mr_access_reg || idle_start || ((state == ST_RUN) && wr_en_int);

   always_ff @(posedge dqs_inv or negedge rst_n) begin
      if (!rst_n) begin
         state               <= ST_IDLE;
         cnt                 <= 1'b0;
         rd_pg_bndry_expired <= 1'b0;
         xfer_done           <= 1'b0;
         wrap_phase          <= 1'b0;
         rd_last_addr        <= '0;
         beats_left          <= '0;
         wr_en_int           <= 1'b1;
         wrap_cnt            <= '0;
      end else if (stop_read) begin
         // rd_last_addr is deliberately kept so a split transfer can resume from it.
         state               <= ST_IDLE;
         cnt                 <= 1'b0;
         rd_pg_bndry_expired <= 1'b0;
         xfer_done           <= 1'b0;
         wrap_phase          <= 1'b0;
         beats_left          <= '0;
         wr_en_int           <= 1'b0;
         wrap_cnt            <= '0;
      end else if (capture) begin
         cnt          <= 1'b1;
         rd_last_addr <= next_addr;
         beats_left   <= beats_next;
         wrap_phase   <= cur_wrap && !win_complete;
         wrap_cnt     <= wrap_cnt_next;
         if (done_now) begin
            state     <= ST_DONE;
            xfer_done <= 1'b1;
         end else if (page_split) begin
            state               <= ST_EXPIRED;
            rd_pg_bndry_expired <= 1'b1;
            wr_en_int           <= 1'b0;
         end else begin
            state     <= ST_RUN;
            wr_en_int <= 1'b1;
         end
      end
   end

   always_ff @(posedge dqs_inv or negedge rst_n) begin
      if (!rst_n) begin
         dqs_cnt         <= '0;
         min_dqs_cnt_rch <= 1'b0;
      end else if (stop_read) begin
         dqs_cnt         <= '0;
         min_dqs_cnt_rch <= 1'b0;
      end else if (dqs_cnt == DQS_LAST) begin
         min_dqs_cnt_rch <= 1'b1;
      end else begin
         dqs_cnt <= dqs_cnt + 4'd1;
      end
   end

endmodule

// File: tb/tb_rd_xfer_bndry_tracker.sv
// Bench for rd_xfer_bndry_tracker: directed scenarios plus randomized transfers against a
// beat-index address model (address of beat i computed directly from the burst rules).
module tb_rd_xfer_bndry_tracker;

   localparam int AW    = 32;
   localparam int BB    = 2;
   localparam int LW    = 12;
   localparam int MIN_E = 4;

   localparam int S_IDLE = 0, S_RUN = 1, S_EXP = 2, S_DONE = 3;

   logic          dqs_inv = 1'b0;
   logic          rst_n   = 1'b0;
   logic [3:0]    mem_page_size = '0;
   logic          mr_access_reg = 1'b0;
   logic          start_track = 1'b0;
   logic          stop_read = 1'b0;
   logic          wr_rd = 1'b0;
   logic [1:0]    xfer_btype = 2'b01;
   logic [1:0]    wrap_size = '0;
   logic          hybrid_wrap = 1'b0;
   logic          rbx_en = 1'b0;
   logic [AW-1:0] first_addr = '0;
   logic [LW-1:0] xfer_mem_len = '0;
   logic          rcv_dq_fifo_wr_en;
   logic          cnt;
   logic          min_dqs_cnt_rch;
   logic          rd_pg_bndry_expired;
   logic          xfer_done;
   logic          wrap_phase;
   logic [AW-1:0] rd_last_addr;
   logic [LW-1:0] beats_left;

   always #5 dqs_inv = ~dqs_inv;

   rd_xfer_bndry_tracker #(
      .AXI_ADDR_WIDTH(AW), .BEAT_BYTES(BB), .LEN_WIDTH(LW), .MIN_DQS_EDGES(MIN_E)
   ) dut (
      .dqs_inv(dqs_inv), .rst_n(rst_n), .mem_page_size(mem_page_size),
      .mr_access_reg(mr_access_reg), .start_track(start_track), .stop_read(stop_read),
      .wr_rd(wr_rd), .xfer_btype(xfer_btype), .wrap_size(wrap_size),
      .hybrid_wrap(hybrid_wrap), .rbx_en(rbx_en), .first_addr(first_addr),
      .xfer_mem_len(xfer_mem_len), .rcv_dq_fifo_wr_en(rcv_dq_fifo_wr_en), .cnt(cnt),
      .min_dqs_cnt_rch(min_dqs_cnt_rch), .rd_pg_bndry_expired(rd_pg_bndry_expired),
      .xfer_done(xfer_done), .wrap_phase(wrap_phase), .rd_last_addr(rd_last_addr),
      .beats_left(beats_left)
   );

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state
   int          m_state, m_i, m_len, m_W, m_bl, m_since;
   logic [31:0] m_start, m_last;
   bit          m_wrap, m_hyb, m_cnt, m_exp, m_done, m_wp, m_wen;

   function automatic logic [31:0] addr_at(int i);
      int          wb;
      logic [31:0] base, off;
      wb = m_W / BB;
      if (!m_wrap) return m_start + 32'(i * BB);
      base = m_start & ~32'(m_W - 1);
      off  = m_start & 32'(m_W - 1);
      if (!m_hyb || i < wb) return base + ((off + 32'(i * BB)) % 32'(m_W));
      return base + 32'(m_W) + 32'((i - wb) * BB);
   endfunction

   task automatic model_reset();
      m_state = S_IDLE; m_cnt = 0; m_exp = 0; m_done = 0; m_wp = 0;
      m_last = '0; m_bl = 0; m_wen = 1; m_since = 0; m_i = 0;
   endtask

   task automatic model_beat();
      int          wb, rem;
      logic [31:0] nxt;
      bit          inwrap;
      wb     = m_W / BB;
      rem    = m_len - 1 - m_i;
      nxt    = addr_at(m_i + 1);
      inwrap = m_wrap && (m_i < wb);
      m_last = nxt;
      m_bl   = rem;
      m_cnt  = 1;
      m_wp   = m_wrap && ((m_i + 1) < wb);
      if (rem == 0) begin
         m_state = S_DONE; m_done = 1;
      end else if (!inwrap && !rbx_en && mem_page_size >= 6 &&
                   (nxt % (32'd1 << mem_page_size)) == 0) begin
         m_state = S_EXP; m_exp = 1; m_wen = 0;
      end else begin
         m_state = S_RUN; m_wen = 1;
      end
      m_i++;
   endtask

   task automatic model_edge();
      if (stop_read) begin
         m_since = 0;
         m_state = S_IDLE; m_cnt = 0; m_bl = 0; m_exp = 0; m_done = 0; m_wp = 0; m_wen = 0;
      end else begin
         m_since++;
         if (m_state == S_IDLE && start_track && !wr_rd) begin
            m_start = first_addr & ~32'(BB - 1);
            m_wrap  = (xfer_btype == 2'b10);
            m_hyb   = hybrid_wrap;
            m_W     = 16 << wrap_size;
            m_len   = (xfer_mem_len == 0) ? 1 : int'(xfer_mem_len);
            if (m_wrap && !m_hyb && m_len > m_W / BB) m_len = m_W / BB;
            m_i = 0;
            model_beat();
         end else if (m_state == S_RUN) begin
            model_beat();
         end
      end
   endtask

   task automatic check_outputs();
      chk("cnt", cnt, m_cnt);
      chk("min_dqs", min_dqs_cnt_rch, (m_since >= MIN_E));
      chk("expired", rd_pg_bndry_expired, m_exp);
      chk("done", xfer_done, m_done);
      chk("wrap_phase", wrap_phase, m_wp);
      chk("last_addr", rd_last_addr, m_last);
      chk("beats_left", beats_left, m_bl);
   endtask

   // Inputs are set by the caller; check the combinational enable, clock, then check state.
   task automatic tick();
      bit exp_wen;
      #1;
      exp_wen = mr_access_reg || (m_state == S_IDLE && start_track && !wr_rd) ||
                (m_state == S_RUN && m_wen);
      chk("fifo_wr_en", rcv_dq_fifo_wr_en, exp_wen);
      @(posedge dqs_inv);
      model_edge();
      #1;
      check_outputs();
   endtask

   task automatic stop_xfer();
      start_track = 0; mr_access_reg = 0; stop_read = 1;
      tick();
      stop_read = 0;
   endtask

   task automatic start_xfer(input logic [31:0] a, input int len, input logic [1:0] bt,
                             input logic [1:0] ws, input bit hyb, input logic [3:0] pg,
                             input bit rbx);
      first_addr = a; xfer_mem_len = LW'(len); xfer_btype = bt; wrap_size = ws;
      hybrid_wrap = hyb; mem_page_size = pg; rbx_en = rbx;
      start_track = 1; stop_read = 0; wr_rd = 0; mr_access_reg = 0;
      $display("xfer addr=0x%08h len=%0d btype=%0d wsize=%0d hyb=%0d pg=%0d rbx=%0d",
               a, len, bt, ws, hyb, pg, rbx);
   endtask

   initial begin
      int          len, extra;
      logic [31:0] a;
      logic [3:0]  pg;
      logic [1:0]  bt;

      model_reset();
      #12;
      check_outputs();
      chk("reset_wr_en", rcv_dq_fifo_wr_en, 0);
      rst_n = 1;

      // INCR page split
      stop_xfer();
      start_xfer(32'h3C, 8, 2'b01, 2'd0, 0, 4'd6, 0);
      tick(); tick();
      chk("t1_expired", rd_pg_bndry_expired, 1);
      chk("t1_last", rd_last_addr, 32'h40);
      chk("t1_left", beats_left, 6);
      chk("t1_wren", rcv_dq_fifo_wr_en, 0);
      tick();
      chk("t1_hold", rd_last_addr, 32'h40);

      // Same with rbx_en: no split
      stop_xfer();
      start_xfer(32'h3C, 8, 2'b01, 2'd0, 0, 4'd6, 1);
      repeat (8) tick();
      chk("t2_done", xfer_done, 1);
      chk("t2_last", rd_last_addr, 32'h4C);
      chk("t2_expired", rd_pg_bndry_expired, 0);

      // Plain WRAP
      stop_xfer();
      start_xfer(32'h0C, 8, 2'b10, 2'd0, 0, 4'd6, 0);
      repeat (8) tick();
      chk("t3_done", xfer_done, 1);
      chk("t3_last", rd_last_addr, 32'h0C);
      chk("t3_expired", rd_pg_bndry_expired, 0);

      // Hybrid wrap then INCR
      stop_xfer();
      start_xfer(32'h0C, 16, 2'b10, 2'd0, 1, 4'd0, 0);
      repeat (7) tick();
      chk("t4_wp_in", wrap_phase, 1);
      tick();
      chk("t4_wp_out", wrap_phase, 0);
      chk("t4_last8", rd_last_addr, 32'h10);
      tick();
      chk("t4_last9", rd_last_addr, 32'h12);
      repeat (7) tick();
      chk("t4_done", xfer_done, 1);
      chk("t4_last", rd_last_addr, 32'h20);

      // Split and done on the same edge
      stop_xfer();
      start_xfer(32'h38, 4, 2'b01, 2'd0, 0, 4'd6, 0);
      repeat (4) tick();
      chk("t5_done", xfer_done, 1);
      chk("t5_expired", rd_pg_bndry_expired, 0);
      chk("t5_last", rd_last_addr, 32'h40);

      // stop_read mid-transfer, then min DQS count after release
      stop_xfer();
      start_xfer(32'h100, 8, 2'b01, 2'd0, 0, 4'd15, 0);
      repeat (3) tick();
      start_track = 0; stop_read = 1;
      tick();
      chk("t6_left", beats_left, 0);
      chk("t6_last", rd_last_addr, 32'h106);
      chk("t6_cnt", cnt, 0);
      stop_read = 0;
      repeat (3) begin
         tick();
         chk("t6_min_lo", min_dqs_cnt_rch, 0);
      end
      tick();
      chk("t6_min_hi", min_dqs_cnt_rch, 1);

      // Asynchronous reset mid-transfer
      start_xfer(32'h200, 8, 2'b10, 2'd1, 0, 4'd15, 0);
      tick(); tick();
      start_track = 0;
      #2 rst_n = 0;
      model_reset();
      #1;
      check_outputs();
      chk("t7_last", rd_last_addr, 0);
      chk("t7_wr_en", rcv_dq_fifo_wr_en, 0);
      #2 rst_n = 1;

      // Randomized transfers
      for (int t = 0; t < 60; t++) begin
         stop_xfer();
         pg  = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(6, 8)) : 4'($urandom_range(0, 15));
         bt  = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
         len = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 80));
         a   = $urandom;
         if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FF80 | 32'($urandom_range(0, 127));
         start_xfer(a, len, bt, 2'($urandom_range(0, 3)), bit'($urandom_range(0, 1)), pg,
                    bit'($urandom_range(0, 3) == 0));
         wr_rd = ($urandom_range(0, 7) == 0);
         extra = $urandom_range(1, 90);
         for (int c = 0; c < extra; c++) begin
            mr_access_reg = ($urandom_range(0, 5) == 0);
            tick();
            wr_rd = 0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
